fcmp_pipe: RTL

Pipelined, parametrised floating-point comparator for the FPU; successor to the single-function combinational less-than unit.
- Supports LT / LE / EQ selected per operation.
- IEEE-correct zero and NaN handling.
- Configurable exponent/mantissa widths and pipeline depth.
- Sits beside the other FPU units behind the FPU dispatch; uses a valid/ready handshake and drives an idle flag to the core's FPU-busy logic.

---
 rtl/fcmp_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: pipelined floating-point comparator (LT / LE / EQ).
//
// Stage 0 registers the operands together with their NaN / zero decode,
// middle stages are pure delay, and the final stage evaluates the compare
// and registers the one-bit result. With STAGES=1 the decode and the compare
// share the single stage.
//
// The whole pipe advances together unless the result register holds a valid
// result that the consumer refuses. Bubbles are carried, not squeezed out.
//
// Ports:
//   clk, rstn             clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake; in_ready = !stall
//   op                    00=LT 01=LE 10=EQ 11=reserved (flag=0)
//   x1, x2                operands {sign, exp[EXP_W], man[MAN_W]}
//   out_valid / out_ready result handshake
//   y                     {31'b0, flag}
//   idle                  no valid op held in any stage
module fcmp_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            y,
  output logic                   idle
);

  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [1:0] OP_LT = 2'b00;
  localparam logic [1:0] OP_LE = 2'b01;
  localparam logic [1:0] OP_EQ = 2'b10;

  // Decoded operation as carried down the pipe.
  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         nan1;
    logic         nan2;
    logic         zero1;
    logic         zero2;
  } stage_t;

  function automatic stage_t decode(input logic [1:0] o,
                                    input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    stage_t s;
    s.op    = o;
    s.x1    = a;
    s.x2    = b;
    s.nan1  = (&a[W-2:MAN_W]) && (|a[MAN_W-1:0]);
    s.nan2  = (&b[W-2:MAN_W]) && (|b[MAN_W-1:0]);
    s.zero1 = ~|a[W-2:0];
    s.zero2 = ~|b[W-2:0];
    return s;
  endfunction

  // Sign-magnitude ordering: {exp,man} compares as an unsigned integer, so
  // subnormals and infinities fall out of the same magnitude compare.
  function automatic logic cmp_flag(input stage_t s);
    logic [W-2:0] m1, m2;
    logic         s1, s2, lt, eq, both_zero;
    m1        = s.x1[W-2:0];
    m2        = s.x2[W-2:0];
    s1        = s.x1[W-1];
    s2        = s.x2[W-1];
    both_zero = s.zero1 && s.zero2;
    eq        = (s.x1 == s.x2) || both_zero;
    if (both_zero)    lt = 1'b0;
    else if (s1 != s2) lt = s1;
    else if (!s1)     lt = (m1 < m2);
    else              lt = (m1 > m2);
    if (s.nan1 || s.nan2) return 1'b0;
    case (s.op)
      OP_LT:   return lt;
      OP_LE:   return lt || eq;
      OP_EQ:   return eq;
      default: return 1'b0;
    endcase
  endfunction

  logic [STAGES-1:0] vld_pipe_d, vld_pipe_q;
  logic              flag_d, flag_q;
  logic              stall;
  stage_t            dec_in;
  stage_t            fin_src;   // operands feeding the final-stage compare

  assign out_valid = vld_pipe_q[STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign idle      = ~|vld_pipe_q;
  assign y         = {31'b0, flag_q};
  assign dec_in    = decode(op, x1, x2);

  // Valid shift register: every stage moves together or all hold.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (!stall) begin
      vld_pipe_d[0] = in_valid;
      for (int i = 1; i < STAGES; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe_q <= '0;
    else       vld_pipe_q <= vld_pipe_d;
  end

  generate
    if (STAGES == 1) begin : g_single
      assign fin_src = dec_in;
    end else begin : g_multi
      // Stages 0..STAGES-2 carry decoded operands; the last stage holds only
      // the result flag.
      stage_t pipe_d [STAGES-1];
      stage_t pipe_q [STAGES-1];

      always_comb begin
        pipe_d = pipe_q;
        if (!stall) begin
          pipe_d[0] = dec_in;
          for (int i = 1; i < STAGES-1; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < STAGES-1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign fin_src = pipe_q[STAGES-2];
    end
  endgenerate

  // Result register only loads when a valid op lands in the final stage, so
  // y holds across bubbles and stalls.
  always_comb begin
    flag_d = flag_q;
    if (!stall && vld_pipe_d[STAGES-1]) flag_d = cmp_flag(fin_src);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) flag_q <= 1'b0;
    else       flag_q <= flag_d;
  end

endmodule
